uart_tx_ctrl: RTL and testbench



---
 rtl/uart_tx_ctrl.sv | 113 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: sequences start, LSB-first data, optional parity
// and stop for each accepted byte. It drives the select, data and parity
// inputs of the registered TX output mux, at one bit per CLK cycle.
// mux_sel encoding: 00 start, 01 stop/idle, 10 data, 11 parity.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy,
    output logic                  DATA_ACK
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  par_en_q;
    logic                  accept;
    logic                  last_bit;

    // A byte is taken only while the line is idle or finishing a stop bit,
    // so back-to-back frames need no idle gap between them.
    assign accept   = DATA_VALID && ((state == IDLE) || (state == STOP));
    assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign ser_data = shreg[0];

    // State register; reset forces IDLE at once, even in the middle of a frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and Moore output decode (outputs depend on state only).
    always_comb begin
        next_state = state;
        mux_sel    = 2'b01;
        busy       = 1'b0;
        DATA_ACK   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = START;
                end
            end
            START: begin
                mux_sel    = 2'b00;
                busy       = 1'b1;
                DATA_ACK   = 1'b1;
                next_state = DATA;
            end
            DATA: begin
                mux_sel = 2'b10;
                busy    = 1'b1;
                if (last_bit) begin
                    next_state = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                mux_sel    = 2'b11;
                busy       = 1'b1;
                next_state = STOP;
            end
            STOP: begin
                busy       = 1'b1;
                next_state = accept ? START : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Frame datapath: capture the byte and its parity on acceptance, then
    // shift one bit out per DATA cycle while counting the bits sent.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            par_en_q <= 1'b0;
            par_bit  <= 1'b0;
        end else if (accept) begin
            shreg    <= P_DATA;
            par_en_q <= PAR_EN;
            par_bit  <= PAR_TYP ? ~^P_DATA : ^P_DATA;
        end else if (state == START) begin
            bit_cnt <= '0;
        end else if (state == DATA) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl: walks whole frames cycle by
// cycle and compares select, data, parity, busy and acknowledge with
// hand-computed values.
module tb_uart_tx_ctrl;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [1:0] mux_sel;
    logic       ser_data;
    logic       par_bit;
    logic       busy;
    logic       DATA_ACK;

    int total = 0;
    int bad   = 0;

    uart_tx_ctrl #(.DATA_WIDTH(8), .CNT_W(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .mux_sel    (mux_sel),
        .ser_data   (ser_data),
        .par_bit    (par_bit),
        .busy       (busy),
        .DATA_ACK   (DATA_ACK)
    );

    // Free-running clock, period 10.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic pen, input logic ptyp);
        DATA_VALID = v;
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
    endtask

    // Advance one cycle and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkState(input string tag, input logic [1:0] msel, input logic bsy, input logic ack);
        checkOutput({tag, ".mux_sel"}, 8'(mux_sel), 8'(msel));
        checkOutput({tag, ".busy"}, 8'(busy), 8'(bsy));
        checkOutput({tag, ".ack"}, 8'(DATA_ACK), 8'(ack));
    endtask

    // Follows one frame from START through STOP. Inputs are changed after
    // START (vm/dm), disturbed mid-DATA, and set for the STOP cycle (vs/ds).
    task automatic expectFrame(input string tag, input logic [7:0] d, input logic pen,
                               input logic exp_par, input logic vm, input logic [7:0] dm,
                               input logic vs, input logic [7:0] ds,
                               input logic pens, input logic ptyps);
        int busy_cycles;
        busy_cycles = 0;
        step();
        checkState({tag, ".start"}, 2'b00, 1'b1, 1'b1);
        busy_cycles += int'(busy);
        applyStimulus(vm, dm, pens, ptyps);
        for (int i = 0; i < 8; i++) begin
            step();
            checkState({tag, ".data"}, 2'b10, 1'b1, 1'b0);
            checkOutput({tag, ".ser_data"}, 8'(ser_data), 8'(d[i]));
            busy_cycles += int'(busy);
            if (i == 3) applyStimulus(1'b1, 8'hFF, ~pen, 1'b1);
            if (i == 5) applyStimulus(vm, dm, pens, ptyps);
        end
        if (pen) begin
            step();
            checkState({tag, ".parity"}, 2'b11, 1'b1, 1'b0);
            checkOutput({tag, ".par_bit"}, 8'(par_bit), 8'(exp_par));
            busy_cycles += int'(busy);
        end
        step();
        checkState({tag, ".stop"}, 2'b01, 1'b1, 1'b0);
        checkOutput({tag, ".par_hold"}, 8'(par_bit), 8'(exp_par));
        busy_cycles += int'(busy);
        checkOutput({tag, ".busy_len"}, 8'(busy_cycles), 8'(32'd10 + 32'(pen)));
        applyStimulus(vs, ds, pens, ptyps);
    endtask

    initial begin
        RST = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        #12;
        checkState("reset", 2'b01, 1'b0, 1'b0);
        checkOutput("reset.ser_data", 8'(ser_data), 8'h00);
        checkOutput("reset.par_bit", 8'(par_bit), 8'h00);
        RST = 1'b0;

        // Reset in the middle of a frame (START cycle), then long idle.
        step();
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
        step();
        checkState("pre_rst.start", 2'b00, 1'b1, 1'b1);
        #2 RST = 1'b1;
        #1 checkState("mid_rst", 2'b01, 1'b0, 1'b0);
        RST = 1'b0;
        applyStimulus(1'b0, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            checkState("idle_after_rst", 2'b01, 1'b0, 1'b0);
        end

        // 0xA5, even parity.
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
        expectFrame("a5", 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        checkState("a5.idle", 2'b01, 1'b0, 1'b0);

        // 0x01, no parity bit (even parity register value 1).
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
        expectFrame("x01", 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        checkState("x01.idle", 2'b01, 1'b0, 1'b0);

        // Odd parity: 0x07 -> 0, 0x03 -> 1.
        applyStimulus(1'b1, 8'h07, 1'b1, 1'b1);
        expectFrame("x07", 8'h07, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        checkState("x07.idle", 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h03, 1'b1, 1'b1);
        expectFrame("x03", 8'h03, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        checkState("x03.idle", 2'b01, 1'b0, 1'b0);

        // Back-to-back: valid held high, data switched to 0xC3 in STOP.
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
        expectFrame("bb1", 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 8'hC3, 1'b0, 1'b0);
        expectFrame("bb2", 8'hC3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkState("bb.idle", 2'b01, 1'b0, 1'b0);
        end

        // Reset during the 4th DATA cycle of 0x96; next frame starts at bit 0.
        applyStimulus(1'b1, 8'h96, 1'b1, 1'b0);
        step();
        checkState("r6.start", 2'b00, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        checkState("r6.data4", 2'b10, 1'b1, 1'b0);
        checkOutput("r6.data4.ser_data", 8'(ser_data), 8'h00);
        #2 RST = 1'b1;
        #1 checkState("r6.rst", 2'b01, 1'b0, 1'b0);
        checkOutput("r6.rst.ser_data", 8'(ser_data), 8'h00);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checkState("r6.idle", 2'b01, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 8'h96, 1'b1, 1'b0);
        expectFrame("r6.again", 8'h96, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        checkState("r6.again.idle", 2'b01, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
